// File: rtl/dual_cam_line_sched.sv
// Per-pixel source scheduler for the dual-camera combiner: picks cam1 / cam0 FIFO / fused / black
// for each output pixel and drives the cam0 line-FIFO read strobe, alternating top and bottom halves.
`timescale 1ns/1ps
module dual_cam_line_sched #(
  parameter int H_ACT  = 640,
  parameter int OFFSET = 80,
  parameter int BLEND  = 10,
  parameter int CNT_W  = 12
) (
  input  logic             cmos0_pclk,
  input  logic             sys_rst_n,
  input  logic             cmos0_vsync,
  input  logic             cmos1_href,
  input  logic             fifo_empty,
  input  logic             cmos0_en,
  input  logic             cmos1_en,
  input  logic             splicing_en,
  output logic             fifo_rd_en,
  output logic             pixel_href,
  output logic             pixel_vsync,
  output logic [1:0]       src_sel,
  output logic             half_sel,
  output logic [CNT_W-1:0] pix_cnt,
  output logic             underrun
);

  localparam logic [CNT_W-1:0] LAST_ACT = CNT_W'(H_ACT - 1);
  localparam logic [CNT_W-1:0] LAST_SPL = CNT_W'(OFFSET + H_ACT - 1);
  localparam logic [CNT_W-1:0] OFS      = CNT_W'(OFFSET);
  localparam logic [CNT_W-1:0] BLD_END  = CNT_W'(OFFSET + BLEND);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  localparam logic [1:0] SRC_BLACK = 2'b00;
  localparam logic [1:0] SRC_CAM1  = 2'b01;
  localparam logic [1:0] SRC_CAM0  = 2'b10;
  localparam logic [1:0] SRC_FUSED = 2'b11;

  typedef enum logic [2:0] {IDLE, TOP_CAM1, TOP_CAM0, SPLICE, WAIT_LOW} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] pix_nxt;
  logic             spl_lat, spl_nxt;
  logic             h1_meta, h1s, h1s_d, vs_d;
  logic             h1_rise, h1_fall, vs_rise, half_nxt;
  logic             href_c;
  logic [1:0]       src_c;

  // cam1 href crosses clock domains; vsync is already local
  always_ff @(posedge cmos0_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h1_meta <= 1'b0;
      h1s     <= 1'b0;
      h1s_d   <= 1'b0;
      vs_d    <= 1'b0;
    end else begin
      h1_meta <= cmos1_href;
      h1s     <= h1_meta;
      h1s_d   <= h1s;
      vs_d    <= cmos0_vsync;
    end
  end

  assign h1_rise  = h1s & ~h1s_d;
  assign h1_fall  = ~h1s & h1s_d;
  assign vs_rise  = cmos0_vsync & ~vs_d;
  assign half_nxt = half_sel ^ vs_rise;

  always_ff @(posedge cmos0_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      pix_cnt     <= '0;
      spl_lat     <= 1'b0;
      half_sel    <= 1'b0;
      underrun    <= 1'b0;
      pixel_href  <= 1'b0;
      src_sel     <= SRC_BLACK;
      pixel_vsync <= 1'b0;
    end else begin
      state       <= state_nxt;
      pix_cnt     <= pix_nxt;
      spl_lat     <= spl_nxt;
      half_sel    <= half_nxt;
      underrun    <= vs_rise ? 1'b0 : (underrun | (fifo_rd_en & fifo_empty));
      pixel_href  <= href_c;
      // an empty read returns garbage, so show black for that pixel
      src_sel     <= (fifo_rd_en & fifo_empty) ? SRC_BLACK : src_c;
      pixel_vsync <= cmos0_vsync & ~half_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pix_nxt    = pix_cnt;
    spl_nxt    = spl_lat;
    href_c     = 1'b0;
    src_c      = SRC_BLACK;
    fifo_rd_en = 1'b0;
    case (state)
      IDLE: begin
        if (h1_rise) begin
          pix_nxt   = '0;
          spl_nxt   = splicing_en;
          state_nxt = half_sel ? SPLICE : TOP_CAM1;
        end
      end
      TOP_CAM1: begin
        href_c = 1'b1;
        src_c  = cmos1_en ? SRC_CAM1 : SRC_BLACK;
        if (h1_fall || pix_cnt == LAST_ACT) begin
          state_nxt = TOP_CAM0;
          pix_nxt   = '0;
        end else begin
          pix_nxt = pix_cnt + ONE;
        end
      end
      TOP_CAM0: begin
        href_c     = 1'b1;
        fifo_rd_en = 1'b1;
        src_c      = cmos0_en ? SRC_CAM0 : SRC_BLACK;
        if (pix_cnt == LAST_ACT) begin
          state_nxt = h1s ? WAIT_LOW : IDLE;
          pix_nxt   = '0;
        end else begin
          pix_nxt = pix_cnt + ONE;
        end
      end
      SPLICE: begin
        href_c     = 1'b1;
        // reads run even when splicing is off so the FIFO never carries a stale line
        fifo_rd_en = (pix_cnt >= OFS);
        if (!spl_lat)            src_c = SRC_BLACK;
        else if (pix_cnt < OFS)  src_c = SRC_CAM1;
        else if (pix_cnt < BLD_END) src_c = SRC_FUSED;
        else                     src_c = SRC_CAM0;
        if (pix_cnt == LAST_SPL) begin
          state_nxt = h1s ? WAIT_LOW : IDLE;
          pix_nxt   = '0;
        end else begin
          pix_nxt = pix_cnt + ONE;
        end
      end
      WAIT_LOW: begin
        if (!h1s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (vs_rise) begin
      state_nxt = IDLE;
      pix_nxt   = '0;
    end
  end

endmodule
